wb_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port Wishbone-style memory `mem_wb` between two requesters, for example a CPU-side master and a DMA/test master. It sits directly in front of `mem_wb`, serialises accesses, forwards one requester's `we`/`strb`/`addr`/`wdata` at a time, and returns `rdata`/`ack` to the granted requester only. A timeout watchdog aborts any access that `mem_wb` never acknowledges and reports the failure to the requester.

---
 rtl/wb_mem_arbiter_pkg.sv | 15 +
 rtl/wb_mem_arbiter_rr_arb2.sv | 22 ++
 rtl/wb_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and default widths for the two-port Wishbone memory arbiter.
package wb_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/wb_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the port not granted last time wins.
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_grant,
  output logic     gnt_valid,
  output port_id_t gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port Wishbone-style memory between two requesters,
// with a watchdog that aborts unacknowledged accesses.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              err1,
  output logic              mem_we,
  output logic              mem_strb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state, state_nxt;
  port_id_t          last_grant, last_grant_nxt;
  port_id_t          gnt, gnt_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              mem_we_nxt, mem_strb_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
  logic              ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;

  logic              pick_valid;
  port_id_t          pick_id;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt_valid  (pick_valid),
    .gnt_id     (pick_id)
  );

  // State and every output are registered here; all decisions live in the comb block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_strb   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      cnt        <= cnt_nxt;
      mem_we     <= mem_we_nxt;
      mem_strb   <= mem_strb_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      err0       <= err0_nxt;
      err1       <= err1_nxt;
    end
  end

  // Next state and next output values; ack/err default low so they are single-cycle pulses.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    cnt_nxt        = cnt;
    mem_we_nxt     = mem_we;
    mem_strb_nxt   = mem_strb;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    err0_nxt       = 1'b0;
    err1_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nxt       = pick_id;
          mem_we_nxt    = pick_id ? we1    : we0;
          mem_addr_nxt  = pick_id ? addr1  : addr0;
          mem_wdata_nxt = pick_id ? wdata1 : wdata0;
          mem_strb_nxt  = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = BUSY;
        end
      end

      BUSY: begin
        if (mem_ack) begin
          mem_strb_nxt   = 1'b0;
          mem_we_nxt     = 1'b0;
          last_grant_nxt = gnt;
          state_nxt      = DONE;
          if (gnt) begin
            ack1_nxt = 1'b1;
            if (!mem_we) rdata1_nxt = mem_rdata;
          end else begin
            ack0_nxt = 1'b1;
            if (!mem_we) rdata0_nxt = mem_rdata;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          mem_strb_nxt   = 1'b0;
          last_grant_nxt = gnt;
          state_nxt      = DONE;
          if (gnt) err1_nxt = 1'b1;
          else     err0_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // One dead cycle so the requester can drop req after seeing ack/err.
      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter with a zero-wait memory stub.
module tb_wb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [7:0] rdata0, rdata1;
  logic       ack0, err0, ack1, err1;
  logic       mem_we, mem_strb, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic       ack_en = 1'b1;
  logic       stray_ack = 1'b0;
  logic [7:0] mem_array [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .ack1(ack1), .err1(err1),
    .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Zero-wait memory stub: acks in the first strobe cycle unless disabled.
  assign mem_ack   = (mem_strb & ack_en) | stray_ack;
  assign mem_rdata = mem_array[mem_addr];

  always @(posedge clk) begin
    if (mem_strb && mem_ack && mem_we) mem_array[mem_addr] <= mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if ({mem_strb, mem_we, ack0, ack1, err0, err1} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {mem_strb, mem_we, ack0, ack1, err0, err1}); end
    checks++;
    if ({mem_addr, mem_wdata, rdata0, rdata1} !== 32'h0)
      begin errors++; $display("FAIL reset_data got %h exp 00000000", {mem_addr, mem_wdata, rdata0, rdata1}); end
    #2;
    rst = 1'b0;
    tick;
    checks++;
    if (mem_strb !== 1'b0) begin errors++; $display("FAIL idle_no_req strb got %b exp 0", mem_strb); end
  endtask

  task automatic test_write_read;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 8'hA5;
    tick;
    checks++;
    if ({mem_strb, mem_we, mem_addr, mem_wdata, ack0} !== {1'b1, 1'b1, 8'h12, 8'hA5, 1'b0})
      begin errors++; $display("FAIL wr_strobe got %b/%b/%h/%h/%b exp 1/1/12/a5/0", mem_strb, mem_we, mem_addr, mem_wdata, ack0); end
    tick;
    checks++;
    if ({ack0, ack1, mem_strb, rdata0} !== {1'b1, 1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL wr_ack got ack0=%b ack1=%b strb=%b rdata0=%h exp 1/0/0/00", ack0, ack1, mem_strb, rdata0); end
    req0 = 1'b0;
    tick;
    checks++;
    if (ack0 !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b exp 0", ack0); end
    req0 = 1'b1; we0 = 1'b0;
    tick;
    checks++;
    if ({mem_strb, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h12})
      begin errors++; $display("FAIL rd_strobe got %b/%b/%h exp 1/0/12", mem_strb, mem_we, mem_addr); end
    tick;
    checks++;
    if ({ack0, ack1, rdata0} !== {1'b1, 1'b0, 8'hA5})
      begin errors++; $display("FAIL rd_ack got ack0=%b ack1=%b rdata0=%h exp 1/0/a5", ack0, ack1, rdata0); end
    req0 = 1'b0;
    tick;
  endtask

  task automatic test_simultaneous;
    int   g0, g1;
    logic prev;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    g0 = -1; g1 = -1; prev = 1'b0;
    for (int i = 1; i <= 20 && (req0 || req1); i++) begin
      tick;
      if (mem_strb && !prev) begin
        if (mem_addr == 8'h01) g0 = i;
        else if (mem_addr == 8'h02) g1 = i;
      end
      prev = mem_strb;
      if (ack0) begin
        req0 = 1'b0; checks++;
        if (rdata0 !== 8'h11) begin errors++; $display("FAIL sim_rdata0 got %h exp 11", rdata0); end
      end
      if (ack1) begin
        req1 = 1'b0; checks++;
        if (rdata1 !== 8'h22) begin errors++; $display("FAIL sim_rdata1 got %h exp 22", rdata1); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (g0 !== 1) begin errors++; $display("FAIL sim_grant0 got cycle %0d exp 1", g0); end
    checks++;
    if (g1 !== 4) begin errors++; $display("FAIL sim_grant1 got cycle %0d exp 4", g1); end
  endtask

  task automatic test_fairness;
    int   gr [8];
    int   n;
    logic prev;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
    n = 0; prev = mem_strb;
    for (int i = 0; i < 40 && n < 8; i++) begin
      tick;
      if (mem_strb && !prev) begin
        gr[n] = (mem_addr == 8'h31) ? 1 : 0;
        n++;
      end
      prev = mem_strb;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL fair_count got %0d exp 8", n); end
    for (int j = 0; j < n; j++) begin
      checks++;
      if (gr[j] !== (j % 2)) begin errors++; $display("FAIL fair_seq[%0d] got %0d exp %0d", j, gr[j], j % 2); end
    end
    for (int i = 0; i < 6 && !(ack0 || ack1); i++) tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
    checks++;
    if (rdata1 !== 8'h5C) begin errors++; $display("FAIL fair_rdata1 got %h exp 5c", rdata1); end
  endtask

  task automatic test_timeout;
    ack_en = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    tick;
    checks++;
    if (mem_strb !== 1'b1) begin errors++; $display("FAIL to_strobe got %b exp 1", mem_strb); end
    for (int i = 1; i <= 15; i++) begin
      tick;
      checks++;
      if (i < 15) begin
        if ({err1, mem_strb} !== 2'b01)
          begin errors++; $display("FAIL to_wait[%0d] got err1=%b strb=%b exp 0/1", i, err1, mem_strb); end
      end else begin
        if ({err1, mem_strb, ack1, rdata1} !== {1'b1, 1'b0, 1'b0, 8'h5C})
          begin errors++; $display("FAIL to_err got err1=%b strb=%b ack1=%b rdata1=%h exp 1/0/0/5c", err1, mem_strb, ack1, rdata1); end
      end
    end
    req1 = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({ack0, ack1, err1, mem_strb, rdata1} !== {4'b0, 8'h5C})
        begin errors++; $display("FAIL late_ack[%0d] got ack0=%b ack1=%b err1=%b strb=%b rdata1=%h exp 0/0/0/0/5c", i, ack0, ack1, err1, mem_strb, rdata1); end
    end
    stray_ack = 1'b0;
    ack_en = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    for (int i = 0; i < 6 && !ack0; i++) tick;
    req0 = 1'b0;
    checks++;
    if ({ack0, rdata0} !== {1'b1, 8'h11}) begin errors++; $display("FAIL pre_read got ack0=%b rdata0=%h exp 1/11", ack0, rdata0); end
    tick;
    tick;
    ack_en = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h50; wdata0 = 8'h77;
    tick;
    checks++;
    if (mem_strb !== 1'b1) begin errors++; $display("FAIL mid_strobe got %b exp 1", mem_strb); end
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_strb, mem_we, ack0, ack1, err0, err1, rdata0} !== {6'b0, 8'h00})
      begin errors++; $display("FAIL async_reset got %b rdata0=%h exp 000000/00", {mem_strb, mem_we, ack0, ack1, err0, err1}, rdata0); end
    req0 = 1'b0;
    tick;
    rst = 1'b0;
    ack_en = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    tick;
    checks++;
    if ({mem_strb, mem_addr} !== {1'b1, 8'h01})
      begin errors++; $display("FAIL post_reset_grant got strb=%b addr=%h exp 1/01", mem_strb, mem_addr); end
    for (int i = 0; i < 12 && (req0 || req1); i++) begin
      tick;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (mem_array[8'h50] !== 8'h00) begin errors++; $display("FAIL no_replay got %h exp 00", mem_array[8'h50]); end
    tick;
  endtask

  task automatic test_held;
    int   rises, r2, acks;
    logic prev;
    tick;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    rises = 0; r2 = -1; acks = 0; prev = mem_strb;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (mem_strb && !prev) begin
        rises++;
        if (rises == 2) r2 = i;
      end
      if (ack0) begin
        acks++;
        checks++;
        if (prev !== 1'b1) begin errors++; $display("FAIL ack_wo_strobe at %0d got prev_strb=%b exp 1", i, prev); end
      end
      prev = mem_strb;
      if (i == 5) req0 = 1'b0;
    end
    checks++;
    if (rises !== 2) begin errors++; $display("FAIL held_rises got %0d exp 2", rises); end
    checks++;
    if (r2 !== 4) begin errors++; $display("FAIL held_second_grant got cycle %0d exp 4", r2); end
    checks++;
    if ({acks, rdata0} !== {32'd2, 8'hC3}) begin errors++; $display("FAIL held_acks got %0d rdata0=%h exp 2/c3", acks, rdata0); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_array[i] = 8'h00;
    mem_array[8'h01] = 8'h11;
    mem_array[8'h02] = 8'h22;
    mem_array[8'h30] = 8'hC3;
    mem_array[8'h31] = 8'h5C;
    test_reset;
    test_write_read;
    test_simultaneous;
    test_fairness;
    test_timeout;
    test_reset_mid;
    test_held;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

endmodule
